// File: rtl/mem_req_ctrl_pkg.sv
// Shared constants and helpers for the memory-request subsystem:
// response queue depth, legal read latencies and response-entry layout.
package mem_req_ctrl_pkg;

    // Response queue depth; also the maximum number of outstanding read credits.
    localparam int RSP_DEPTH = 4;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    // Legal memory read latencies (cycles after the memory samples rd_en).
    localparam int RD_LAT_UNREG = 1;
    localparam int RD_LAT_REG   = 2;

    // Response entry layout: {err, data}. Data width follows MEM_WIDTH.
    localparam int RSP_ERR_W = 1;

    // Kind of command presented to the memory in a given cycle.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } mem_cmd_e;

    // Width of one response entry for a given data width.
    function automatic int rsp_entry_w(input int data_w);
        return data_w + RSP_ERR_W;
    endfunction

    // True when a read latency is supported by the capture pipeline.
    function automatic bit rd_lat_legal(input int lat);
        return (lat == RD_LAT_UNREG) || (lat == RD_LAT_REG);
    endfunction

    // Memory stores odd parity over bit 0: good parity is ~dout[0].
    function automatic logic parity_mismatch(input logic parity, input logic dout_lsb);
        return parity != ~dout_lsb;
    endfunction

endpackage

// File: rtl/mem_req_ctrl_rsp_fifo.sv
// rsp_fifo: small circular response queue with a combinational head.
// Pointers wrap modulo DEPTH; simultaneous push and pop keep occupancy.
module rsp_fifo
    import mem_req_ctrl_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Advance a pointer, wrapping at DEPTH (works for non-power-of-two depths).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = store_q[rd_ptr_q];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    // Upstream credit accounting must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !do_pop));

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready front end for a single-port synchronous memory.
// Requests are registered onto the memory command port one per cycle; read
// data returns RD_LATENCY cycles later and is queued in a credit-protected
// response FIFO so the memory never has to stall.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH     = 16,
    parameter int ADDR_SIZE     = 10,
    parameter int RD_LATENCY    = 2,
    parameter int PARITY_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [MEM_WIDTH-1:0] req_wdata,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,

    output logic [MEM_WIDTH-1:0] mem_din,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic                 mem_blk_select,
    output logic                 mem_addr_en,
    output logic                 mem_dout_en,
    input  logic [MEM_WIDTH-1:0] mem_dout,
    input  logic                 mem_parity
);

    localparam int ENTRY_W = rsp_entry_w(MEM_WIDTH);

    logic                 req_acc;
    logic                 rd_acc;
    logic                 rsp_pop;
    mem_cmd_e             cmd;

    logic [RSP_CNT_W-1:0] credits_q, credits_d;

    logic                 mem_blk_select_q, mem_blk_select_d;
    logic                 mem_wr_en_q, mem_wr_en_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0] mem_din_q, mem_din_d;

    // Bit i set: a read accepted i edges ago; top bit marks data on mem_dout.
    logic [RD_LATENCY:0]  rd_vld_q, rd_vld_d;

    logic                 cap_vld;
    logic                 cap_err;
    logic [ENTRY_W-1:0]   cap_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic                 fifo_empty;

    // Ready only from credits so acceptance never depends on request contents;
    // a read accepted here always has a FIFO slot reserved for its data.
    assign req_ready = (credits_q < RSP_CNT_W'(RSP_DEPTH));
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && !req_we;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Classify what, if anything, is issued to memory next cycle.
    always_comb begin
        cmd = CMD_IDLE;
        if (req_acc) begin
            cmd = req_we ? CMD_WRITE : CMD_READ;
        end
    end

    // Next memory command; address and data hold when idle.
    always_comb begin
        mem_blk_select_d = (cmd != CMD_IDLE);
        mem_wr_en_d      = (cmd == CMD_WRITE);
        mem_rd_en_d      = (cmd == CMD_READ);
        mem_addr_d       = mem_addr_q;
        mem_din_d        = mem_din_q;
        if (cmd != CMD_IDLE) begin
            mem_addr_d = req_addr;
            mem_din_d  = req_wdata;
        end
    end

    // Credits count reads in flight plus queued responses.
    always_comb begin
        credits_d = credits_q;
        case ({rd_acc, rsp_pop})
            2'b10:   credits_d = credits_q + RSP_CNT_W'(1);
            2'b01:   credits_d = credits_q - RSP_CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Shift read-valid markers toward the capture point.
    always_comb begin
        rd_vld_d = {rd_vld_q[RD_LATENCY-1:0], rd_acc};
    end

    // Command, credit and read-tracking registers; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q        <= '0;
            rd_vld_q         <= '0;
            mem_blk_select_q <= 1'b0;
            mem_wr_en_q      <= 1'b0;
            mem_rd_en_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_din_q        <= '0;
        end else begin
            credits_q        <= credits_d;
            rd_vld_q         <= rd_vld_d;
            mem_blk_select_q <= mem_blk_select_d;
            mem_wr_en_q      <= mem_wr_en_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_addr_q       <= mem_addr_d;
            mem_din_q        <= mem_din_d;
        end
    end

    // Capture side: build the response entry from the memory read port.
    always_comb begin
        cap_vld   = rd_vld_q[RD_LATENCY];
        cap_err   = (PARITY_ENABLE != 0) ? parity_mismatch(mem_parity, mem_dout[0]) : 1'b0;
        cap_entry = {cap_err, mem_dout};
    end

    rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_vld),
        .push_data (cap_entry),
        .pop       (rsp_pop),
        .pop_data  (head_entry),
        .empty     (fifo_empty)
    );

    // Head is presented combinationally; zeroed when the queue is empty so the
    // response port reads clean after reset.
    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = rsp_valid ? head_entry[MEM_WIDTH-1:0] : '0;
    assign rsp_err   = rsp_valid && head_entry[ENTRY_W-1];

    assign mem_blk_select = mem_blk_select_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_addr_en    = 1'b0;
    assign mem_dout_en    = 1'b1;

    a_rd_latency_legal: assert property (@(posedge clk) rd_lat_legal(RD_LATENCY));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credits_q <= RSP_CNT_W'(RSP_DEPTH));

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 16, SHALL set the data width of request, response and memory ports.
REQ-002 Parameter ADDR_SIZE, default 10, SHALL set the address width.
REQ-003 Parameter RD_LATENCY, default 2, legal values 1 or 2, SHALL equal the memory read latency in cycles after the memory samples rd_en (1 = unregistered dout, 2 = registered dout).
REQ-004 Parameter PARITY_ENABLE, default 1, SHALL enable the response parity check.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready at an edge.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_SIZE  request address.
REQ-011 req_wdata  in  MEM_WIDTH  write data.
REQ-012 rsp_valid  out  1  read response present.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge.
REQ-014 rsp_rdata  out  MEM_WIDTH  read data.
REQ-015 rsp_err  out  1  parity mismatch on this response.
REQ-016 mem_din, mem_addr, mem_wr_en, mem_rd_en, mem_blk_select  out  MEM_WIDTH/ADDR_SIZE/1/1/1  memory command, all registered.
REQ-017 mem_addr_en  out  1  tied 0; mem_dout_en  out  1  tied 1.
REQ-018 mem_dout  in  MEM_WIDTH; mem_parity  in  1  memory read data and parity.

Function
REQ-019 Accepted requests SHALL be issued to memory in acceptance order, with one request per cycle and no bubbles between them.
REQ-020 A request accepted at edge k SHALL drive its command on the mem_* outputs during the cycle after edge k: mem_blk_select=1, mem_wr_en=req_we, mem_rd_en=!req_we, and addr/din copied from the request.
REQ-021 In any cycle with no accepted request, the memory outputs SHALL be: mem_blk_select=0, mem_wr_en=0, mem_rd_en=0; mem_addr and mem_din SHALL hold their last values.
REQ-022 A read accepted at edge k SHALL be captured from mem_dout/mem_parity at edge k+1+RD_LATENCY into the response FIFO, which is tracked by a RD_LATENCY+1 deep valid-shift pipeline.
REQ-023 The response FIFO SHALL have a fixed depth RSP_DEPTH=4 and SHALL present its head combinationally, so that rsp_valid is first high in the cycle after the capture edge.
REQ-024 A credit counter (0..RSP_DEPTH) SHALL count in-flight reads plus FIFO entries; it SHALL +1 on read accept, -1 on response pop, and stay unchanged when both occur at the same edge.
REQ-025 req_ready SHALL be 1 iff credits < RSP_DEPTH; it SHALL not depend on req_valid or req_we, and writes SHALL be blocked while credits are full.
REQ-026 The FIFO SHALL never overflow; a capture into a full FIFO is a design error to be flagged by an assertion.
REQ-027 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-028 With PARITY_ENABLE=1, rsp_err SHALL equal (mem_parity != ~mem_dout[0]) at capture; with PARITY_ENABLE=0, rsp_err SHALL be 0.
REQ-029 A write followed by a read to the same address SHALL return the new data, with no stall.
REQ-030 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo RSP_DEPTH.

Reset
REQ-031 While rst=1 at an edge, the block SHALL clear: credits, FIFO pointers and occupancy, the valid-shift pipeline, mem_wr_en, mem_rd_en, mem_blk_select, mem_addr and mem_din.
REQ-032 After reset, req_ready=1, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-033 Reset mid-operation SHALL drop all in-flight reads and discard their data.
REQ-034 In the first cycle after rst deasserts, no memory command SHALL be issued.

Structure
REQ-035 RSP_DEPTH, the legal RD_LATENCY values and the response-entry field widths SHALL live in the shared memory-subsystem package/include.
REQ-036 The response FIFO SHALL be a sub-module named rsp_fifo with parameters WIDTH=MEM_WIDTH+1 and DEPTH.

Verification
REQ-037 Reset-then-idle: assert rst for 3 cycles -> req_ready=1, rsp_valid=0, and all mem_* enables stay 0.
REQ-038 Write then read: write addr 0x005 data 0xA5A4, then read 0x005 back-to-back with rsp_ready=1 -> rsp_rdata=0xA5A4, rsp_err=0, rsp_valid high exactly RD_LATENCY+2 cycles after the read accept (run with RD_LATENCY=1 and 2).
REQ-039 Backpressure: hold rsp_ready=0 and issue 6 reads -> exactly 4 are accepted, req_ready=0 afterwards, and rsp_rdata is stable; release rsp_ready -> 4 in-order responses, then req_ready=1.
REQ-040 Simultaneous: with credits=4, pop one response and present a read in the same cycle -> the read is accepted only in the following cycle and credits return to 4.
REQ-041 Parity: force mem_parity to mismatch on one read -> that response has rsp_err=1; with PARITY_ENABLE=0 -> rsp_err=0.
REQ-042 Reset mid-flight: issue 2 reads and assert rst one cycle later -> no rsp_valid afterwards and credits=0.
